// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor front-end and the vending_machine bench.
package coin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUAL,
    ST_FIRE,
    ST_REJ,
    ST_WAIT_REL,
    ST_LOCKOUT
  } state_t;

  localparam logic COIN_5  = 1'b0;
  localparam logic COIN_10 = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Multi-flop synchroniser for one asynchronous slot sensor line.
module coin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front-end: synchronise, debounce, one coin at a time, emit clean
// one-cycle c5/c10/reject pulses.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw_c5,
  input  logic i_raw_c10,
  input  logic i_accept_en,
  output logic o_c5,
  output logic o_c10,
  output logic o_reject,
  output logic o_busy
);

  localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic w_s5;
  logic w_s10;

  coin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c5 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_raw_c5),
    .o_q   (w_s5)
  );

  coin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c10 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_raw_c10),
    .o_q   (w_s10)
  );

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_coin;
  logic             w_coin_nxt;
  logic             w_lat_line;
  logic             w_oth_line;

  logic r_c5;
  logic r_c10;
  logic r_reject;
  logic r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_coin_nxt  = r_coin;
    w_lat_line  = (r_coin == COIN_10) ? w_s10 : w_s5;
    w_oth_line  = (r_coin == COIN_10) ? w_s5  : w_s10;

    case (r_state)
      ST_IDLE: begin
        if (w_s5 ^ w_s10) begin
          w_state_nxt = ST_QUAL;
          w_coin_nxt  = w_s10 ? COIN_10 : COIN_5;
          w_cnt_nxt   = CNT_ONE;
        end else if (w_s5 && w_s10) begin
          w_state_nxt = ST_REJ;
        end
      end

      ST_QUAL: begin
        if (!w_lat_line) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_oth_line) begin
          w_state_nxt = ST_REJ;
        end else if (r_cnt == DEB_LAST) begin
          // accept_en matters only here; FIRE/REJ ignore later changes.
          w_state_nxt = i_accept_en ? ST_FIRE : ST_REJ;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_FIRE, ST_REJ: begin
        w_state_nxt = ST_WAIT_REL;
        w_cnt_nxt   = '0;
      end

      ST_WAIT_REL: begin
        if (w_s5 || w_s10) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (LOCKOUT_CYCLES == 0) ? ST_IDLE : ST_LOCKOUT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_LOCKOUT: begin
        if (r_cnt == LOCK_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_WAIT_REL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_WAIT_REL;
      r_cnt   <= '0;
      r_coin  <= COIN_5;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_coin  <= w_coin_nxt;
    end
  end

  // Outputs registered from the next state so each pulse coincides with FIRE/REJ.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c5     <= 1'b0;
      r_c10    <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_c5     <= (w_state_nxt == ST_FIRE) && (w_coin_nxt == COIN_5);
      r_c10    <= (w_state_nxt == ST_FIRE) && (w_coin_nxt == COIN_10);
      r_reject <= (w_state_nxt == ST_REJ);
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_c5     = r_c5;
  assign o_c10    = r_c10;
  assign o_reject = r_reject;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor at default parameters.
module tb_coin_acceptor;
  import coin_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic raw_c5;
  logic raw_c10;
  logic accept_en;
  logic c5;
  logic c10;
  logic reject;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  logic [127:0] lg_c5;
  logic [127:0] lg_c10;
  logic [127:0] lg_rej;
  logic [127:0] lg_busy;
  logic [2:0]   prev_out;

  coin_acceptor #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .LOCKOUT_CYCLES  (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_raw_c5    (raw_c5),
    .i_raw_c10   (raw_c10),
    .i_accept_en (accept_en),
    .o_c5        (c5),
    .o_c10       (c10),
    .o_reject    (reject),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    cyc     = 0;
    lg_c5   = '0;
    lg_c10  = '0;
    lg_rej  = '0;
    lg_busy = '0;
  endtask

  // One active edge; log outputs after it; check exclusivity and no back-to-back pulses.
  task automatic tick();
    logic [2:0] now_out;
    @(posedge clk);
    #1;
    now_out = {c5, c10, reject};
    if (now_out != 3'b000) begin
      chk("onehot", 32'($countones(now_out)), 32'd1);
      chk("no_repeat", 32'(now_out & prev_out), 32'd0);
    end
    prev_out = now_out;
    if (cyc < 128) begin
      lg_c5[cyc]   = c5;
      lg_c10[cyc]  = c10;
      lg_rej[cyc]  = reject;
      lg_busy[cyc] = busy;
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int nth_idx(input logic [127:0] v, input int n);
    int seen = 0;
    for (int i = 0; i < 128; i++) begin
      if (v[i]) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic wait_idle(input string tag, output int edges);
    edges = 0;
    while (busy && edges < 40) begin
      tick();
      edges++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  int e;

  initial begin
    rst = 1'b1; raw_c5 = 1'b0; raw_c10 = 1'b0; accept_en = 1'b1;
    prev_out = '0;
    clr_log();
    ticks(3);
    chk("rst_c5", 32'(c5), 0);
    chk("rst_c10", 32'(c10), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_state", 32'(dut.r_state), 32'(ST_WAIT_REL));
    rst = 1'b0;
    wait_idle("init_idle", e);
    chk("init_idle_edges", 32'(e), 32'd6);

    // 1: c5 held 10 cycles
    clr_log();
    raw_c5 = 1'b1; ticks(10);
    raw_c5 = 1'b0; ticks(12);
    chk("t1_c5_count", 32'($countones(lg_c5)), 32'd1);
    chk("t1_c5_edge", 32'(nth_idx(lg_c5, 0)), 32'd5);
    chk("t1_c10_count", 32'($countones(lg_c10)), 32'd0);
    chk("t1_rej_count", 32'($countones(lg_rej)), 32'd0);
    chk("t1_busy_e16", 32'(lg_busy[16]), 32'd1);
    chk("t1_busy_e17", 32'(lg_busy[17]), 32'd0);

    // 2: c10 bouncing
    clr_log();
    raw_c10 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raw_c10 = ~raw_c10;
      tick();
    end
    raw_c10 = 1'b0; ticks(6);
    chk("t2_pulses", 32'($countones(lg_c5 | lg_c10 | lg_rej)), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_state", 32'(dut.r_state), 32'(ST_IDLE));

    // 3: both lines together
    clr_log();
    raw_c5 = 1'b1; raw_c10 = 1'b1; ticks(4);
    raw_c5 = 1'b0; raw_c10 = 1'b0; ticks(4);
    chk("t3_rej_count", 32'($countones(lg_rej)), 32'd1);
    chk("t3_rej_by_e3", 32'(nth_idx(lg_rej, 0) >= 0 && nth_idx(lg_rej, 0) <= 3), 32'd1);
    chk("t3_coin_count", 32'($countones(lg_c5 | lg_c10)), 32'd0);
    wait_idle("t3_idle", e);

    // 4: accept_en low when qualifying; raising it afterwards must not matter
    clr_log();
    accept_en = 1'b0; raw_c10 = 1'b1; ticks(6);
    accept_en = 1'b1; ticks(2);
    raw_c10 = 1'b0; ticks(2);
    chk("t4_rej_edge", 32'(nth_idx(lg_rej, 0)), 32'd5);
    chk("t4_rej_count", 32'($countones(lg_rej)), 32'd1);
    chk("t4_c10_count", 32'($countones(lg_c10)), 32'd0);
    wait_idle("t4_idle", e);

    // 5: line high across reset release
    raw_c5 = 1'b1; rst = 1'b1; ticks(3);
    rst = 1'b0;
    clr_log();
    ticks(20);
    chk("t5_no_pulse", 32'($countones(lg_c5 | lg_c10 | lg_rej)), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    raw_c5 = 1'b0;
    wait_idle("t5_release_idle", e);
    clr_log();
    raw_c5 = 1'b1; ticks(10);
    raw_c5 = 1'b0;
    chk("t5_reins_edge", 32'(nth_idx(lg_c5, 0)), 32'd5);
    chk("t5_reins_count", 32'($countones(lg_c5)), 32'd1);
    wait_idle("t5_reins_idle", e);

    // 6: reset on the FIRE cycle
    raw_c5 = 1'b1; ticks(6);
    chk("t6_fire", 32'(c5), 32'd1);
    rst = 1'b1; tick();
    chk("t6_rst_c5", 32'(c5), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd1);
    chk("t6_rst_state", 32'(dut.r_state), 32'(ST_WAIT_REL));
    rst = 1'b0; raw_c5 = 1'b0;
    wait_idle("t6_idle", e);
    chk("t6_idle_edges", 32'(e), 32'd6);

    // 6b: back-to-back coins separated by lockout
    clr_log();
    raw_c5 = 1'b1; ticks(8);
    raw_c5 = 1'b0; ticks(5);
    raw_c5 = 1'b1; ticks(10);
    raw_c5 = 1'b0; ticks(10);
    chk("t6b_count", 32'($countones(lg_c5)), 32'd2);
    chk("t6b_first", 32'(nth_idx(lg_c5, 0)), 32'd5);
    chk("t6b_second", 32'(nth_idx(lg_c5, 1)), 32'd19);
    chk("t6b_gap", 32'((nth_idx(lg_c5, 1) - nth_idx(lg_c5, 0)) >= 7), 32'd1);
    wait_idle("t6b_idle", e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
